serial_subtractor: RTL



---
 rtl/serial_subtractor_if.sv | 33 +++
 rtl/serial_subtractor.sv | 117 +++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// Defining SUB_OVERFLOW_EN adds the ovf result signal.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
`ifdef SUB_OVERFLOW_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bo
`ifdef SUB_OVERFLOW_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bo
`ifdef SUB_OVERFLOW_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B - BI, LSB first, one bit per clock.
// Optional macro SUB_OVERFLOW_EN adds a two's-complement overflow flag.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  sub_if
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, d_q, d_d;
    logic             br_q, br_d, bo_q, bo_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             diff, br_next;
`ifdef SUB_OVERFLOW_EN
    // Operand sign bits are shifted out of a_q/b_q, so keep copies.
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

    always_comb begin
        diff    = a_q[0] ^ b_q[0] ^ br_q;
        br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        d_d     = d_q;
        br_d    = br_q;
        bo_d    = bo_q;
        cnt_d   = cnt_q;
`ifdef SUB_OVERFLOW_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (sub_if.start) begin
                    a_d     = sub_if.a;
                    b_d     = sub_if.b;
                    br_d    = sub_if.bi;
                    cnt_d   = '0;
`ifdef SUB_OVERFLOW_EN
                    a_msb_d = sub_if.a[WIDTH-1];
                    b_msb_d = sub_if.b[WIDTH-1];
`endif
                    state_d = StSub;
                end
            end
            StSub: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = {diff, r_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    d_d     = {diff, r_q[WIDTH-1:1]};
                    bo_d    = br_next;
`ifdef SUB_OVERFLOW_EN
                    // diff is the result MSB on the final bit.
                    ovf_d   = (a_msb_q ^ b_msb_q) & (diff ^ a_msb_q);
`endif
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SUB_OVERFLOW_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
            cnt_q   <= cnt_d;
`ifdef SUB_OVERFLOW_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sub_if.busy = (state_q == StSub);
    assign sub_if.done = (state_q == StDone);
    assign sub_if.d    = d_q;
    assign sub_if.bo   = bo_q;
`ifdef SUB_OVERFLOW_EN
    assign sub_if.ovf  = ovf_q;
`endif
endmodule
